instruction_fetch: RTL and testbench

- Upstream neighbour of the instruction decode stage in the 3-bit machine (8 opcodes, 3-bit operands).
- Holds the program in an on-chip word memory that is loaded serially. Keeps the instruction pointer (pc) and presents one opcode/operand pair per cycle to decode.
- Redirects on taken jumps reported by execute, and raises halt when pc runs past the end of the program.

---
 rtl/instruction_fetch_pkg.sv | 25 ++
 rtl/instruction_fetch_prog_mem.sv | 34 +++
 rtl/instruction_fetch.sv | 154 +++++++++++++++
 tb/tb_instruction_fetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the 3-bit machine fetch stage: opcodes, fetch FSM
// state encodings and the default program store depth.
package instruction_fetch_pkg;

    // Default number of 3-bit words in the program store.
    localparam int IF_PROG_DEPTH = 16;

    // Instruction set of the 3-bit machine.
    typedef enum logic [2:0] {
        ADV = 3'd0,
        BXL = 3'd1,
        BST = 3'd2,
        JNZ = 3'd3,
        BXC = 3'd4,
        OUT = 3'd5,
        BDV = 3'd6,
        CDV = 3'd7
    } opcode_e;

    // Fetch FSM encodings.
    localparam logic [1:0] FETCH_IDLE   = 2'd0;
    localparam logic [1:0] FETCH_RUN    = 2'd1;
    localparam logic [1:0] FETCH_HALTED = 2'd2;

endpackage

// File: rtl/instruction_fetch_prog_mem.sv
// Program store: DEPTH x 3-bit register file, one synchronous write port and
// two asynchronous read ports. Addresses are one bit wider than needed so
// that pc+1 may point one past the end; such reads return 0.
module instruction_fetch_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [2:0]    wr_data_i,
    input  logic [AW:0]   rd_addr_a_i,
    output logic [2:0]    rd_data_a_o,
    input  logic [AW:0]   rd_addr_b_i,
    output logic [2:0]    rd_data_b_o
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [2:0] mem_q [DEPTH];

    // Synchronous write port.
    // NOTE: storage has no reset on purpose; it keeps the program across rst
    // and maps onto plain flops or RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = (rd_addr_a_i < DEPTH_W) ? mem_q[rd_addr_a_i[AW-1:0]] : 3'd0;
    assign rd_data_b_o = (rd_addr_b_i < DEPTH_W) ? mem_q[rd_addr_b_i[AW-1:0]] : 3'd0;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the program store, walks pc two words at a
// time, presents opcode/operand pairs to decode, redirects on taken jumps
// (deferring them across stalls) and halts when pc runs off the program.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int PROG_DEPTH = IF_PROG_DEPTH,
    parameter int AW         = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_wr_en,
    input  logic [AW-1:0] prog_wr_addr,
    input  logic [2:0]    prog_wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          stall,
    input  logic          jump_taken,
    input  logic [2:0]    jump_target,
    output logic [2:0]    opcode,
    output logic [2:0]    operand,
    output logic          instr_valid,
    output logic [AW:0]   pc_out,
    output logic          halt
);

    logic [1:0]  state_q,     state_d;
    logic [AW:0] pc_q,        pc_d;
    logic [AW:0] len_q,       len_d;
    logic        jump_pend_q, jump_pend_d;
    logic [2:0]  target_q,    target_d;
    logic [2:0]  opcode_q,    opcode_d;
    logic [2:0]  operand_q,   operand_d;
    logic        valid_q,     valid_d;
    logic [AW:0] pc_out_q,    pc_out_d;
    logic        halt_q,      halt_d;

    logic [AW:0]   pc_plus1;
    logic [AW+1:0] pc_plus1_wide;
    logic [2:0]    mem_op;
    logic [2:0]    mem_opd;
    logic          mem_wr_en;

    assign pc_plus1      = pc_q + (AW+1)'(1);
    // End-of-program compare is one bit wider so it can never wrap.
    assign pc_plus1_wide = {1'b0, pc_q} + (AW+2)'(1);
    assign mem_wr_en     = prog_wr_en && (state_q != FETCH_RUN);

    instruction_fetch_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk         (clk),
        .wr_en_i     (mem_wr_en),
        .wr_addr_i   (prog_wr_addr),
        .wr_data_i   (prog_wr_data),
        .rd_addr_a_i (pc_q),
        .rd_data_a_o (mem_op),
        .rd_addr_b_i (pc_plus1),
        .rd_data_b_o (mem_opd)
    );

    // Next-state logic for the fetch FSM, pc, pending jump and output registers.
    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        jump_pend_d = jump_pend_q;
        target_d    = target_q;
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        valid_d     = valid_q;
        pc_out_d    = pc_out_q;
        halt_d      = halt_q;

        case (state_q)
            FETCH_IDLE, FETCH_HALTED: begin
                if (start) begin
                    state_d     = FETCH_RUN;
                    len_d       = prog_len;
                    pc_d        = '0;
                    halt_d      = 1'b0;
                    valid_d     = 1'b0;
                    jump_pend_d = 1'b0;
                end
            end
            FETCH_RUN: begin
                if (stall) begin
                    // Hold everything, but remember a jump resolved meanwhile.
                    if (jump_taken) begin
                        jump_pend_d = 1'b1;
                        target_d    = jump_target;
                    end
                end else if (jump_taken || jump_pend_q) begin
                    // Redirect and drop the fall-through instruction already fetched.
                    pc_d        = jump_taken ? (AW+1)'(jump_target) : (AW+1)'(target_q);
                    jump_pend_d = 1'b0;
                    valid_d     = 1'b0;
                end else if (pc_plus1_wide >= {1'b0, len_q}) begin
                    state_d = FETCH_HALTED;
                    halt_d  = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    opcode_d  = mem_op;
                    operand_d = mem_opd;
                    pc_out_d  = pc_q;
                    valid_d   = 1'b1;
                    pc_d      = pc_q + (AW+1)'(2);
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-high reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            jump_pend_q <= 1'b0;
            target_q    <= '0;
            opcode_q    <= '0;
            operand_q   <= '0;
            valid_q     <= 1'b0;
            pc_out_q    <= '0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            jump_pend_q <= jump_pend_d;
            target_q    <= target_d;
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            valid_q     <= valid_d;
            pc_out_q    <= pc_out_d;
            halt_q      <= halt_d;
        end
    end

    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign halt        = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Each scenario task drives a short
// step table and compares the packed output bundle
// {opcode, operand, instr_valid, pc_out, halt} against hand-computed values.
module tb_instruction_fetch;

    localparam int PROG_DEPTH = 16;
    localparam int AW         = 4;

    logic          clk;
    logic          rst;
    logic          prog_wr_en;
    logic [AW-1:0] prog_wr_addr;
    logic [2:0]    prog_wr_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          stall;
    logic          jump_taken;
    logic [2:0]    jump_target;
    logic [2:0]    opcode;
    logic [2:0]    operand;
    logic          instr_valid;
    logic [AW:0]   pc_out;
    logic          halt;

    int checks = 0;
    int errors = 0;

    logic [12:0] obs;
    assign obs = {opcode, operand, instr_valid, pc_out, halt};

    instruction_fetch #(
        .PROG_DEPTH (PROG_DEPTH),
        .AW         (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_wr_en   (prog_wr_en),
        .prog_wr_addr (prog_wr_addr),
        .prog_wr_data (prog_wr_data),
        .prog_len     (prog_len),
        .start        (start),
        .stall        (stall),
        .jump_taken   (jump_taken),
        .jump_target  (jump_target),
        .opcode       (opcode),
        .operand      (operand),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out),
        .halt         (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle in the same order as obs.
    function automatic logic [12:0] ev(input logic [2:0] op, input logic [2:0] od,
                                       input logic v, input logic [4:0] pc, input logic h);
        return {op, od, v, pc, h};
    endfunction

    // Advance one clock and settle away from the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] addr, input logic [2:0] data);
        prog_wr_en   = 1'b1;
        prog_wr_addr = addr;
        prog_wr_data = data;
        tick();
        prog_wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic [AW:0] len);
        prog_len = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", obs, 13'd0);
        end
        checks++;
        rst = 1'b0;
        // IDLE ignores stall and jump_taken.
        stall       = 1'b1;
        jump_taken  = 1'b1;
        jump_target = 3'd5;
        tick();
        stall      = 1'b0;
        jump_taken = 1'b0;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL idle_ignore got %h expected %h", obs, 13'd0);
        end
        checks++;
    endtask

    task automatic test_basic;
        logic [12:0] exp_t [5];
        exp_t = '{ev(0,3,1,0,0), ev(5,4,1,2,0), ev(3,0,1,4,0),
                  ev(3,0,0,4,1), ev(3,0,0,4,1)};
        write_word(4'd0, 3'd0);
        write_word(4'd1, 3'd3);
        write_word(4'd2, 3'd5);
        write_word(4'd3, 3'd4);
        write_word(4'd4, 3'd3);
        write_word(4'd5, 3'd0);
        do_start(5'd6);
        for (int i = 0; i < 5; i++) begin
            // Last step: a jump while HALTED must be ignored.
            if (i == 4) begin
                jump_taken  = 1'b1;
                jump_target = 3'd0;
            end
            tick();
            jump_taken = 1'b0;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL basic_step%0d got %h expected %h", i, obs, exp_t[i]);
            end
            checks++;
        end
    endtask

    task automatic test_jump;
        logic [12:0] exp_t [8];
        exp_t = '{ev(0,3,1,0,0), ev(5,4,1,2,0), ev(3,0,1,4,0), ev(3,0,0,4,0),
                  ev(0,3,1,0,0), ev(5,4,1,2,0), ev(3,0,1,4,0), ev(3,0,0,4,1)};
        do_start(5'd6);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                jump_taken  = 1'b1;
                jump_target = 3'd0;
            end
            tick();
            jump_taken = 1'b0;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL jump_step%0d got %h expected %h", i, obs, exp_t[i]);
            end
            checks++;
        end
    endtask

    task automatic test_stall;
        logic [12:0] exp_t [9];
        exp_t = '{ev(0,3,1,0,0), ev(5,4,1,2,0), ev(5,4,1,2,0), ev(5,4,1,2,0),
                  ev(5,4,1,2,0), ev(5,4,0,2,0), ev(5,4,1,2,0), ev(3,0,1,4,0),
                  ev(3,0,0,4,1)};
        do_start(5'd6);
        for (int i = 0; i < 9; i++) begin
            stall = (i >= 2 && i <= 4);
            if (i == 3) begin
                jump_taken  = 1'b1;
                jump_target = 3'd2;
            end
            tick();
            jump_taken = 1'b0;
            stall      = 1'b0;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL stall_step%0d got %h expected %h", i, obs, exp_t[i]);
            end
            checks++;
        end
    endtask

    task automatic test_odd_len;
        logic [12:0] exp_t [4];
        exp_t = '{ev(0,3,1,0,0), ev(5,4,1,2,0), ev(5,4,0,2,1), ev(5,4,0,2,1)};
        do_start(5'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL odd_len_step%0d got %h expected %h", i, obs, exp_t[i]);
            end
            checks++;
        end
    endtask

    task automatic test_jump_past_end;
        logic [12:0] exp_t [8];
        exp_t = '{ev(0,3,1,0,0), ev(0,3,0,0,0), ev(0,3,0,0,1), ev(0,3,0,0,0),
                  ev(6,3,1,0,0), ev(5,4,1,2,0), ev(3,0,1,4,0), ev(3,0,0,4,1)};
        do_start(5'd6);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                jump_taken  = 1'b1;
                jump_target = 3'd7;
            end
            // Rewrite word 0 and restart in the same HALTED cycle.
            if (i == 3) begin
                prog_wr_en   = 1'b1;
                prog_wr_addr = 4'd0;
                prog_wr_data = 3'd6;
                prog_len     = 5'd6;
                start        = 1'b1;
            end
            tick();
            jump_taken = 1'b0;
            prog_wr_en = 1'b0;
            start      = 1'b0;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL past_end_step%0d got %h expected %h", i, obs, exp_t[i]);
            end
            checks++;
        end
        write_word(4'd0, 3'd0);
    endtask

    task automatic test_rst_mid_run;
        logic [12:0] exp_t [4];
        exp_t = '{ev(0,3,1,0,0), ev(5,4,1,2,0), ev(3,0,1,4,0), ev(3,0,0,4,1)};
        do_start(5'd6);
        tick();
        if (obs !== ev(0,3,1,0,0)) begin
            errors++;
            $display("FAIL rst_pre got %h expected %h", obs, ev(0,3,1,0,0));
        end
        checks++;
        // Write during RUN must be ignored (word 2 stays 5).
        prog_wr_en   = 1'b1;
        prog_wr_addr = 4'd2;
        prog_wr_data = 3'd7;
        tick();
        prog_wr_en = 1'b0;
        if (obs !== ev(5,4,1,2,0)) begin
            errors++;
            $display("FAIL rst_pre2 got %h expected %h", obs, ev(5,4,1,2,0));
        end
        checks++;
        #2;
        rst = 1'b1;
        #1;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL rst_async got %h expected %h", obs, 13'd0);
        end
        checks++;
        #1;
        rst = 1'b0;
        tick();
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL rst_idle got %h expected %h", obs, 13'd0);
        end
        checks++;
        do_start(5'd6);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL rerun_step%0d got %h expected %h", i, obs, exp_t[i]);
            end
            checks++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        prog_wr_en   = 1'b0;
        prog_wr_addr = '0;
        prog_wr_data = '0;
        prog_len     = '0;
        start        = 1'b0;
        stall        = 1'b0;
        jump_taken   = 1'b0;
        jump_target  = '0;

        test_reset();
        test_basic();
        test_jump();
        test_stall();
        test_odd_len();
        test_jump_past_end();
        test_rst_mid_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
